// File: rtl/uart_pkg.sv
// Shared constants for the parametrised UART transmitter: parity modes,
// stop-bit counts and FSM state encodings.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int STOP_ONE = 1;
  localparam int STOP_TWO = 2;

  // Each state names the next bit that will be driven onto the line.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DATA  = 3'd1;
  localparam logic [2:0] ST_PAR   = 3'd2;
  localparam logic [2:0] ST_STOP1 = 3'd3;
  localparam logic [2:0] ST_STOP2 = 3'd4;

endpackage

// File: rtl/uart_tx_param_if.sv
// Word-side handshake between a producer and the UART transmitter.
interface uart_tx_param_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] data_in;
  logic              start;
  logic              ready;
  logic              busy;
  logic              done;

  modport master (output data_in, output start, input ready, input busy, input done);
  modport slave  (input data_in, input start, output ready, output busy, output done);

endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: one-word holding register, configurable
// parity / stop bits / bit order, bit timing from an external tx_en strobe.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY    = PAR_ODD,
  parameter int STOP_BITS = STOP_ONE,
  parameter int MSB_FIRST = 0
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            tx_en,
  uart_tx_param_if.slave  bus,
  output logic            tx
);

  localparam int              CW   = $clog2(DATA_W);
  localparam logic [CW-1:0]   LAST = CW'(DATA_W - 1);

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     bit_idx;
  logic              hold_valid;
  logic              done;
  logic [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0] shift_reg;
  logic              par_bit;
  logic              accept;
  logic              launch;

  function automatic logic parity_of(input logic [DATA_W-1:0] w);
    return (PARITY == PAR_EVEN) ? ^w : ~^w;
  endfunction

  assign accept    = bus.start && !hold_valid;
  assign launch    = tx_en && (state == ST_IDLE) && hold_valid;
  assign bus.ready = ~hold_valid;
  assign bus.busy  = (state != ST_IDLE) || hold_valid;
  assign bus.done  = done;

  always_comb begin
    bit_idx = cnt;
    if (MSB_FIRST != 0) bit_idx = LAST - cnt;
  end

  // Datapath registers carry no reset; they are only consumed under hold_valid / state.
  always_ff @(posedge clk) begin
    if (accept) hold_reg <= bus.data_in;
    if (launch) begin
      shift_reg <= hold_reg;
      par_bit   <= parity_of(hold_reg);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      hold_valid <= 1'b0;
      cnt        <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) hold_valid <= 1'b1;
      if (tx_en) begin
        case (state)
          ST_IDLE: begin
            if (hold_valid) begin
              tx         <= 1'b0;
              hold_valid <= 1'b0;
              cnt        <= '0;
              state      <= ST_DATA;
            end
          end
          ST_DATA: begin
            tx <= shift_reg[bit_idx];
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_PAR: begin
            tx    <= par_bit;
            state <= ST_STOP1;
          end
          ST_STOP1: begin
            tx <= 1'b1;
            if (STOP_BITS == STOP_ONE) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              state <= ST_STOP2;
            end
          end
          ST_STOP2: begin
            tx    <= 1'b1;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: three configurations, expected line
// bits queued at accept time and checked on every active tx_en.
module tb_uart_tx_param;

  typedef struct packed {
    logic tx;
    logic dn;
  } exp_t;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] tx_en;
  logic [2:0] tx_w, ready_w, busy_w, done_w;

  int total = 0;
  int bad   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  // 0: defaults (8 bits, odd, 1 stop, LSB first)
  uart_tx_param_if #(.DATA_W(8)) if0 ();
  uart_tx_param #(.DATA_W(8), .PARITY(2), .STOP_BITS(1), .MSB_FIRST(0)) dut0 (
    .clk(clk), .resetN(rst_n[0]), .tx_en(tx_en[0]), .bus(if0), .tx(tx_w[0]));

  // 1: 8 bits, even, 2 stops, MSB first
  uart_tx_param_if #(.DATA_W(8)) if1 ();
  uart_tx_param #(.DATA_W(8), .PARITY(1), .STOP_BITS(2), .MSB_FIRST(1)) dut1 (
    .clk(clk), .resetN(rst_n[1]), .tx_en(tx_en[1]), .bus(if1), .tx(tx_w[1]));

  // 2: 7 bits, no parity, 1 stop, LSB first
  uart_tx_param_if #(.DATA_W(7)) if2 ();
  uart_tx_param #(.DATA_W(7), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(0)) dut2 (
    .clk(clk), .resetN(rst_n[2]), .tx_en(tx_en[2]), .bus(if2), .tx(tx_w[2]));

  assign ready_w = {if2.ready, if1.ready, if0.ready};
  assign busy_w  = {if2.busy,  if1.busy,  if0.busy};
  assign done_w  = {if2.done,  if1.done,  if0.done};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Frame bits in line order, first bit at v[n-1]; done expected on the last.
  task automatic push_frame(input int i, input logic [15:0] v, input int n);
    exp_t e;
    for (int k = n - 1; k >= 0; k--) begin
      e.tx = v[k];
      e.dn = (k == 0);
      case (i)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic drive_word(input int i, input logic [8:0] d, input logic s);
    case (i)
      0: begin if0.data_in = d[7:0]; if0.start = s; end
      1: begin if1.data_in = d[7:0]; if1.start = s; end
      default: begin if2.data_in = d[6:0]; if2.start = s; end
    endcase
  endtask

  task automatic send(input int i, input logic [8:0] d, input logic [15:0] v, input int n);
    int w = 0;
    while (!ready_w[i] && w < 2000) begin
      tick();
      w++;
    end
    if (!ready_w[i]) begin
      total++;
      bad++;
      $display("FAIL ready_timeout dut%0d: ready=%0b expected 1", i, ready_w[i]);
    end
    drive_word(i, d, 1'b1);
    push_frame(i, v, n);
    tick();
    drive_word(i, d, 1'b0);
  endtask

  task automatic run_bits(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      repeat (15) tick();
      tx_en[i] = 1'b1;
      tick();
      tx_en[i] = 1'b0;
    end
  endtask

  // Monitor: every tx_en seen while the DUT is busy must drive the next queued bit.
  always begin
    logic [2:0] act;
    exp_t       e;
    logic       empty;
    @(negedge clk);
    act = tx_en & busy_w & rst_n;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (act[i]) begin
        empty = 1'b0;
        e     = '0;
        case (i)
          0: if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
          1: if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
          default: if (q2.size() == 0) empty = 1'b1; else e = q2.pop_front();
        endcase
        if (empty) begin
          total++;
          bad++;
          $display("FAIL unexpected_bit dut%0d: tx=%0b with nothing queued", i, tx_w[i]);
        end else begin
          chk($sformatf("tx_bit dut%0d", i), {31'b0, tx_w[i]}, {31'b0, e.tx});
          chk($sformatf("done dut%0d", i), {31'b0, done_w[i]}, {31'b0, e.dn});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ref_tx;
    logic stable;
    rst_n = 3'b000;
    tx_en = 3'b000;
    drive_word(0, 9'h0, 1'b0);
    drive_word(1, 9'h0, 1'b0);
    drive_word(2, 9'h0, 1'b0);
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_tx dut%0d", i),    {31'b0, tx_w[i]},    32'd1);
      chk($sformatf("rst_ready dut%0d", i), {31'b0, ready_w[i]}, 32'd1);
      chk($sformatf("rst_busy dut%0d", i),  {31'b0, busy_w[i]},  32'd0);
      chk($sformatf("rst_done dut%0d", i),  {31'b0, done_w[i]},  32'd0);
    end
    rst_n = 3'b111;
    repeat (2) tick();

    // 1: A5, odd parity, LSB first
    send(0, 9'hA5, 16'b01010010111, 11);
    run_bits(0, 11);
    chk("t1_busy_end", {31'b0, busy_w[0]}, 32'd0);
    tick();
    chk("t1_done_clear", {31'b0, done_w[0]}, 32'd0);

    // 2: 07, even parity, MSB first, 2 stops; start coincides with tx_en
    drive_word(1, 9'h07, 1'b1);
    tx_en[1] = 1'b1;
    push_frame(1, 16'b000000111111, 12);
    tick();
    drive_word(1, 9'h07, 1'b0);
    tx_en[1] = 1'b0;
    chk("t2_no_same_cycle_start", {31'b0, tx_w[1]}, 32'd1);
    chk("t2_ready_after_accept", {31'b0, ready_w[1]}, 32'd0);
    run_bits(1, 12);
    chk("t2_busy_end", {31'b0, busy_w[1]}, 32'd0);

    // 3: 7-bit back-to-back, second word accepted mid-frame
    send(2, 9'h41, 16'b010000011, 9);
    run_bits(2, 3);
    send(2, 9'h3C, 16'b000111101, 9);
    chk("t3_ready_after_accept", {31'b0, ready_w[2]}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      run_bits(2, 1);
      chk("t3_ready_pending", {31'b0, ready_w[2]}, 32'd0);
    end
    run_bits(2, 1);
    chk("t3_ready_after_start", {31'b0, ready_w[2]}, 32'd1);
    run_bits(2, 8);
    chk("t3_busy_end", {31'b0, busy_w[2]}, 32'd0);

    // 4: start held with ready low must not queue FF
    send(0, 9'h11, 16'b01000100011, 11);
    drive_word(0, 9'hFF, 1'b1);
    repeat (5) tick();
    chk("t4_ready_held", {31'b0, ready_w[0]}, 32'd0);
    drive_word(0, 9'hFF, 1'b0);
    run_bits(0, 11);
    run_bits(0, 12);
    chk("t4_busy_end", {31'b0, busy_w[0]}, 32'd0);

    // 5: asynchronous reset during data bit 3, then a clean frame
    send(0, 9'hA5, 16'b01010010111, 11);
    run_bits(0, 5);
    repeat (3) tick();
    @(posedge clk);
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("t5_async_tx", {31'b0, tx_w[0]}, 32'd1);
    chk("t5_async_busy", {31'b0, busy_w[0]}, 32'd0);
    chk("t5_async_ready", {31'b0, ready_w[0]}, 32'd1);
    q0.delete();
    repeat (3) tick();
    rst_n[0] = 1'b1;
    tick();
    chk("t5_done_after_rst", {31'b0, done_w[0]}, 32'd0);
    send(0, 9'h5A, 16'b00101101011, 11);
    run_bits(0, 11);
    chk("t5_busy_end", {31'b0, busy_w[0]}, 32'd0);

    // 6: strobe stalled for 100 clk mid-frame
    send(0, 9'h3C, 16'b00011110011, 11);
    run_bits(0, 4);
    ref_tx = tx_w[0];
    stable = 1'b1;
    repeat (100) begin
      tick();
      if (tx_w[0] !== ref_tx) stable = 1'b0;
    end
    chk("t6_line_stable", {31'b0, stable}, 32'd1);
    chk("t6_busy_stalled", {31'b0, busy_w[0]}, 32'd1);
    run_bits(0, 7);
    chk("t6_busy_end", {31'b0, busy_w[0]}, 32'd0);

    repeat (4) tick();
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed 7-bit/odd-parity/MSB-first transmitter in the UART experiment. It serialises DATA_W-bit words with configurable parity, stop-bit count and bit order. Bit timing comes from an external one-cycle bit-rate strobe (tx_en) from the baud generator. A one-word holding register gives a valid/ready handshake, so back-to-back frames go out with no idle gap beyond the stop bits.

Parameters:
DATA_W, 8, data bits per frame (5..9)
PARITY, 2, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits (1 or 2)
MSB_FIRST, 0, 0 = LSB transmitted first, 1 = MSB first

Ports:
clk  input  1  system clock, all logic on posedge
resetN  input  1  asynchronous active-low reset
tx_en  input  1  bit-period strobe, one clk wide; every action on the line happens on a tx_en cycle
data_in  input  DATA_W  word to send, sampled on an accept cycle
start  input  1  valid; a word is accepted when start && ready at posedge clk
ready  output  1  holding register empty (= ~hold_valid)
busy  output  1  frame in progress or word pending: (state != IDLE) || hold_valid
done  output  1  one-clk pulse on the tx_en cycle that drives the final stop bit
tx  output  1  serial line, registered, idle high

Behaviour:
- Reset (resetN low, asynchronous): tx=1, state=IDLE, hold_valid=0, bit counter=0, done=0; ready=1, busy=0. All inputs are ignored while reset is asserted. A frame in progress is dropped and the line returns high immediately.
- Accept: start && ready -> hold_reg<=data_in, hold_valid<=1. start while ready=0 is ignored and the word is not queued.
- Each state names the next bit to drive. Transitions and tx updates occur only on cycles with tx_en=1; otherwise everything holds.
- IDLE: on tx_en with hold_valid=1: tx<=0 (start bit), shift_reg<=hold_reg, par_bit<=(PARITY==1 ? ^hold_reg : ~^hold_reg), hold_valid<=0, cnt<=0 -> DATA. With hold_valid=0, tx stays 1.
- DATA: on tx_en: tx<=shift_reg[cnt] (LSB first) or shift_reg[DATA_W-1-cnt] (MSB first); cnt<=cnt+1. When cnt==DATA_W-1: -> PAR if PARITY!=0, else -> STOP1.
- PAR: on tx_en: tx<=par_bit -> STOP1.
- STOP1: on tx_en: tx<=1. If STOP_BITS==1: done<=1 -> IDLE; else -> STOP2.
- STOP2: on tx_en: tx<=1, done<=1 -> IDLE.
- done is registered and cleared on the next clk.
- Parity is placed after the data bits. Even parity: total count of ones in data+parity is even. Odd parity: total is odd.
- Frame length: 1 + DATA_W + (PARITY!=0) + STOP_BITS bit periods. The last stop bit lasts a full period because the next start bit can only be driven on the following tx_en.
- Back-to-back: ready rises on the start-bit cycle. A word accepted during the frame is transmitted on the first tx_en after the last stop bit is driven.
- No collision between accept and transfer: accept requires hold_valid=0 and transfer requires hold_valid=1.
- cnt width is $clog2(DATA_W). It never wraps within a frame.
- start and tx_en arriving in the same cycle while idle and empty: the word is accepted that cycle. The start bit goes out on the next tx_en, never the same cycle.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, DATA, PAR, STOP1, STOP2)
  - parity constants PAR_NONE/PAR_EVEN/PAR_ODD
  - stop-bit constants
- No sub-module: parity is a single reduction, and the strobe comes from the existing baud generator.

Test Plan:
1. Defaults, tx_en every 16 clk, send 8'hA5. tx sampled after each tx_en: 0,1,0,1,0,0,1,0,1,1(parity),1(stop). done pulses once and busy falls after the final tx_en.
2. PARITY=1, MSB_FIRST=1, STOP_BITS=2, send 8'h07: 0,0,0,0,0,0,1,1,1, parity 1, stop 1,1. Frame is 12 periods.
3. PARITY=0, DATA_W=7, send 7'h41 then 7'h3C accepted mid-frame. The second start bit appears on the tx_en immediately after the first frame's stop bit, and ready is 0 between accept and that start bit.
4. start held high with ready=0 carrying 8'hFF while the held word is 8'h11. Only 8'h11 is transmitted and 8'hFF is dropped.
5. Assert resetN=0 during data bit 3 of 8'hA5. tx goes to 1 asynchronously, and busy=0, ready=1 with no clk edge. After release, a new 8'h5A frame is transmitted correctly.
6. tx_en held low for 100 clk mid-frame. tx is stable throughout, and the frame resumes with no lost or duplicated bit.
